// File: rtl/packer_ring.sv
// ---------------------------------------------------------------------------
// packer_ring
//   Packs a stream of right-aligned values of runtime bit width b (1..16)
//   LSB-first, without gaps, into DATA_W-bit words. A block is bounded by a
//   value count. The final, possibly partial, word is zero-padded and tagged
//   with trm_last.
//
// Optional feature (macro PACKER_PERF_COUNTER_EN):
//   Adds a done pulse and saturating input/output stall counters.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle pulse, latches config (ignored unless idle)
//   bitwidth_d           bits per value; 0 or >16 is treated as 16
//   transmitted_values   number of values in the block
//   rcv_valid/ready/data input value stream (value in bits [b-1:0])
//   trm_valid/ready/data output word stream, trm_last on the final word
//   busy                 high whenever a block is in progress
//   done                 (optional) pulse when a block completes
//   in_stall_cycles      (optional) busy && rcv_valid && !rcv_ready cycles
//   out_stall_cycles     (optional) trm_valid && !trm_ready cycles
// ---------------------------------------------------------------------------
module packer_ring #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [4:0]        bitwidth_d,
  input  logic [CNT_W-1:0]  transmitted_values,
  input  logic              rcv_valid,
  input  logic [DATA_W-1:0] rcv_data,
  output logic              rcv_ready,
  output logic              trm_valid,
  output logic [DATA_W-1:0] trm_data,
  output logic              trm_last,
  input  logic              trm_ready,
  output logic              busy
`ifdef PACKER_PERF_COUNTER_EN
  ,
  output logic              done,
  output logic [CNT_W-1:0]  in_stall_cycles,
  output logic [CNT_W-1:0]  out_stall_cycles
`endif
);

  // The accumulator holds up to two words of pending bits.
  localparam int ACC_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(ACC_W) + 1;
  localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [ACC_W-1:0]   w_acc_base;
  logic [ACC_W-1:0]   w_data_m;
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic [FILL_W-1:0]  w_fill_base;
  logic [CNT_W-1:0]   r_remaining;
  logic [4:0]         r_bw;
  logic [DATA_W-1:0]  r_mask;
  logic [4:0]         w_bw_in;
  logic [DATA_W-1:0]  w_mask_in;
  logic               w_start_ok;
  logic               w_accept;
  logic               w_emit;
  logic               w_word_ready;

  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_bw_in      = (bitwidth_d == 5'd0 || bitwidth_d > 5'(DATA_W)) ? 5'(DATA_W) : bitwidth_d;
  assign w_mask_in    = DATA_W'((ACC_W'(1) << w_bw_in) - ACC_W'(1));
  assign w_word_ready = (r_fill >= WORD_BITS);

  // The output word is taken straight from the accumulator register, so it
  // stays stable while the downstream stalls.
  assign trm_data = r_acc[DATA_W-1:0];
  assign busy     = (r_state != S_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    rcv_ready   = 1'b0;
    trm_valid   = 1'b0;
    trm_last    = 1'b0;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && transmitted_values != '0) w_state_nxt = S_PACK;
      end
      S_PACK: begin
        trm_valid = w_word_ready;
        // A draining word frees 16 bits this cycle, so a new value fits even
        // with a full word pending: full throughput at b=16.
        rcv_ready = !w_word_ready || trm_ready;
        w_accept  = rcv_valid && rcv_ready;
        w_emit    = trm_valid && trm_ready;
        if (w_accept && r_remaining == CNT_W'(1)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        trm_valid = (r_fill != '0);
        trm_last  = trm_valid && (r_fill <= WORD_BITS);
        w_emit    = trm_valid && trm_ready;
        if (r_fill == '0 || (w_emit && trm_last)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator update: drain first, then append the masked value above the
  // bits that remain.
  always_comb begin
    w_acc_base  = w_emit ? (r_acc >> DATA_W) : r_acc;
    w_fill_base = w_emit ? (r_fill - WORD_BITS) : r_fill;
    w_data_m    = ACC_W'(rcv_data & r_mask);
    w_acc_nxt   = w_acc_base;
    w_fill_nxt  = w_fill_base;
    if (w_accept) begin
      w_acc_nxt  = w_acc_base | (w_data_m << w_fill_base);
      w_fill_nxt = w_fill_base + FILL_W'(r_bw);
    end
    // The final word may be partial; clear explicitly rather than subtract.
    if (r_state == S_FLUSH && w_state_nxt == S_IDLE) begin
      w_acc_nxt  = '0;
      w_fill_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_fill      <= '0;
      r_remaining <= '0;
      r_bw        <= 5'(DATA_W);
      r_mask      <= '1;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
      if (w_start_ok) begin
        r_bw        <= w_bw_in;
        r_mask      <= w_mask_in;
        r_remaining <= transmitted_values;
      end else if (w_accept) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

`ifdef PACKER_PERF_COUNTER_EN
  logic             r_done;
  logic [CNT_W-1:0] r_in_stall;
  logic [CNT_W-1:0] r_out_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done      <= 1'b0;
      r_in_stall  <= '0;
      r_out_stall <= '0;
    end else begin
      r_done <= (w_start_ok && transmitted_values == '0) ||
                (r_state != S_IDLE && w_state_nxt == S_IDLE);
      if (w_start_ok) begin
        r_in_stall  <= '0;
        r_out_stall <= '0;
      end else begin
        if (busy && rcv_valid && !rcv_ready && !(&r_in_stall))
          r_in_stall <= r_in_stall + CNT_W'(1);
        if (trm_valid && !trm_ready && !(&r_out_stall))
          r_out_stall <= r_out_stall + CNT_W'(1);
      end
    end
  end

  assign done             = r_done;
  assign in_stall_cycles  = r_in_stall;
  assign out_stall_cycles = r_out_stall;
`endif

endmodule

// File: tb/tb_packer_ring.sv
// ---------------------------------------------------------------------------
// tb_packer_ring
//   Self-checking bench for packer_ring. Expected words come from a bit-list
//   model: every accepted value contributes its low b bits to a flat bit
//   queue, which is then cut into 16-bit words, zero-padding the tail.
// ---------------------------------------------------------------------------
module tb_packer_ring;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 32;
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [4:0]        bitwidth_d;
  logic [CNT_W-1:0]  transmitted_values;
  logic              rcv_valid;
  logic [DATA_W-1:0] rcv_data;
  logic              rcv_ready;
  logic              trm_valid;
  logic [DATA_W-1:0] trm_data;
  logic              trm_last;
  logic              trm_ready;
  logic              busy;
`ifdef PACKER_PERF_COUNTER_EN
  logic              done;
  logic [CNT_W-1:0]  in_stall_cycles;
  logic [CNT_W-1:0]  out_stall_cycles;
`endif

  always #5 clk = ~clk;

  packer_ring #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .start              (start),
    .bitwidth_d         (bitwidth_d),
    .transmitted_values (transmitted_values),
    .rcv_valid          (rcv_valid),
    .rcv_data           (rcv_data),
    .rcv_ready          (rcv_ready),
    .trm_valid          (trm_valid),
    .trm_data           (trm_data),
    .trm_last           (trm_last),
    .trm_ready          (trm_ready),
    .busy               (busy)
`ifdef PACKER_PERF_COUNTER_EN
    ,
    .done               (done),
    .in_stall_cycles    (in_stall_cycles),
    .out_stall_cycles   (out_stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int acc_cnt, last_cnt, done_cnt, valid_cnt;
  int first_acc_cyc, last_acc_cyc, first_word_cyc, last_word_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_bw(input int b);
    return (b == 0 || b > 16) ? 16 : b;
  endfunction

  // Reference model: flat bit stream, cut into 16-bit words LSB-first.
  function automatic void build_expected(input int b, input logic [15:0] vals[$]);
    bit          bits[$];
    logic [15:0] w;
    int          eb;
    eb = eff_bw(b);
    exp_q.delete();
    foreach (vals[i])
      for (int k = 0; k < eb; k++) bits.push_back(vals[i][k]);
    while (bits.size() > 0) begin
      w = '0;
      for (int k = 0; k < 16 && bits.size() > 0; k++) w[k] = bits.pop_front();
      exp_q.push_back(w);
    end
  endfunction

  function automatic logic [15:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 16'hxxxx;
  endfunction

  // One block: start, then cycle-by-cycle random valid/ready until idle.
  task automatic run_block(input string name, input int b, input logic [15:0] vals[$],
                           input int vpct, input int rpct, input int stall_n);
    int          n;
    int          idx;
    int          wi;
    int          cyc;
    int          stall_left;
    logic [15:0] m;
    n          = vals.size();
    idx        = 0;
    wi         = 0;
    cyc        = 0;
    stall_left = stall_n;
    m          = (eff_bw(b) == 16) ? 16'hFFFF : 16'((32'd1 << eff_bw(b)) - 1);
    build_expected(b, vals);
    got_q.delete();
    acc_cnt = 0; last_cnt = 0; done_cnt = 0; valid_cnt = 0;
    first_acc_cyc = 0; last_acc_cyc = 0; first_word_cyc = 0; last_word_cyc = 0;

    @(negedge clk);
    start = 1'b1; bitwidth_d = 5'(b); transmitted_values = CNT_W'(n);
    rcv_valid = 1'b0; trm_ready = 1'b0;
    @(negedge clk);
    check({name, " busy after start"}, busy, (n > 0));

    while (cyc < BUDGET) begin
      // Config and start are scrambled while busy; they must be ignored.
      start              = busy && ($urandom_range(7) == 0);
      bitwidth_d         = 5'($urandom);
      transmitted_values = $urandom;
      rcv_valid          = ($urandom_range(99) < vpct);
      rcv_data           = (idx < n) ? ((vals[idx] & m) | (16'($urandom) & ~m)) : 16'($urandom);
      if (trm_valid && stall_left > 0) begin
        trm_ready = 1'b0;
        stall_left--;
      end else begin
        trm_ready = ($urandom_range(99) < rpct);
      end
      #1;
`ifdef PACKER_PERF_COUNTER_EN
      if (done) done_cnt++;
`endif
      if (!busy) break;
      if (trm_valid) valid_cnt++;
      if (rcv_valid && rcv_ready) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
        idx++;
      end
      if (trm_valid && !trm_ready) begin
        check({name, " stalled rcv_ready"}, rcv_ready, 1'b0);
        if (wi < exp_q.size()) check({name, " held word"}, trm_data, exp_q[wi]);
      end
      if (trm_valid && trm_ready) begin
        got_q.push_back(trm_data);
        if (wi < exp_q.size()) begin
          check({name, " word"}, trm_data, exp_q[wi]);
          check({name, " last flag"}, trm_last, (wi == exp_q.size() - 1));
        end
        if (trm_last) last_cnt++;
        if (wi == 0) first_word_cyc = cyc;
        last_word_cyc = cyc;
        wi++;
      end
      @(negedge clk);
      cyc++;
    end

    start = 1'b0; rcv_valid = 1'b0; trm_ready = 1'b0;
    check({name, " finished in budget"}, (cyc < BUDGET), 1'b1);
    check({name, " values accepted"}, acc_cnt, n);
    check({name, " word count"}, got_q.size(), exp_q.size());
    check({name, " last count"}, last_cnt, (exp_q.size() > 0) ? 1 : 0);
`ifdef PACKER_PERF_COUNTER_EN
    check({name, " done pulses"}, done_cnt, 1);
`endif
  endtask

  initial begin
    logic [15:0] vals[$];
    int          seen_valid;

    rstn = 1'b0; start = 1'b0; bitwidth_d = '0; transmitted_values = '0;
    rcv_valid = 1'b0; rcv_data = '0; trm_ready = 1'b0;

    // Reset state.
    #12;
    check("reset busy", busy, 1'b0);
    check("reset rcv_ready", rcv_ready, 1'b0);
    check("reset trm_valid", trm_valid, 1'b0);
    check("reset trm_data", trm_data, 16'h0000);
    check("reset trm_last", trm_last, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // b=4, values 1..8, free-flowing.
    vals = {16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
    run_block("b4", 4, vals, 100, 100, 0);
    check("b4 word0", got_at(0), 16'h4321);
    check("b4 word1", got_at(1), 16'h8765);
    check("b4 idle after", busy, 1'b0);

    // b=5, partial zero-padded tail.
    vals = {16'h1F, 16'h0, 16'h1F, 16'h0};
    run_block("b5", 5, vals, 100, 100, 0);
    check("b5 word0", got_at(0), 16'h7C1F);
    check("b5 word1", got_at(1), 16'h0000);

    // Upper input bits are masked.
    vals = {16'hFFF3, 16'hFFF3, 16'hFFF3, 16'hFFF3};
    run_block("mask", 4, vals, 100, 100, 0);
    check("mask word0", got_at(0), 16'h3333);

    // b=16 full throughput: one accept and one word per cycle.
    vals = {16'($urandom), 16'($urandom), 16'($urandom)};
    run_block("b16", 16, vals, 100, 100, 0);
    check("b16 accept span", last_acc_cyc - first_acc_cyc, 2);
    check("b16 word span", last_word_cyc - first_word_cyc, 2);

    // Downstream stall on the first word for 4 cycles.
    vals = {16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
    run_block("stall", 4, vals, 100, 100, 4);
    check("stall word0", got_at(0), 16'h4321);
    check("stall word1", got_at(1), 16'h8765);
`ifdef PACKER_PERF_COUNTER_EN
    check("stall out_stall_cycles", out_stall_cycles, 4);
    check("stall in_stall_cycles>=4", (in_stall_cycles >= 4), 1'b1);
`endif

    // Reset mid-PACK after 3 values, then a zero-count block.
    @(negedge clk);
    start = 1'b1; bitwidth_d = 5'd4; transmitted_values = 8; trm_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; rcv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rcv_data = 16'(i + 1);
      @(negedge clk);
    end
    rcv_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst trm_valid", trm_valid, 1'b0);
    check("midrst trm_data", trm_data, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (trm_valid || busy) seen_valid++;
    end
    check("midrst quiet after release", seen_valid, 0);
    vals.delete();
    run_block("n0", 4, vals, 100, 100, 0);
    check("n0 trm_valid cycles", valid_cnt, 0);
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (trm_valid || busy) seen_valid++;
    end
    check("n0 quiet after", seen_valid, 0);

    // Randomized blocks, including bitwidth_d of 0 and above 16.
    for (int t = 0; t < 12; t++) begin
      int b;
      int n;
      b = $urandom_range(31);
      n = $urandom_range(24, 1);
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(16'($urandom));
      run_block($sformatf("rnd%0d_b%0d_n%0d", t, b, n), b, vals,
                $urandom_range(100, 40), $urandom_range(100, 40), $urandom_range(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packer_ring.md
Name: packer_ring

Overview:
- Inverse neighbour of the extractor ring; sits directly upstream of it on the compressed path.
- Accepts a stream of right-aligned values of runtime bitwidth b (1..16) and packs them LSB-first, without gaps, into 16-bit words.
- The extractor ring consumes these words when configured with the same bitwidth_d and value count.
- Bounded by a value count; the final, possibly partial, word is flushed zero-padded and tagged last.

Parameters:
- DATA_W, 16, width of input value lane and output word (design verified at 16 only).
- CNT_W, 32, width of value count and performance counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches config and begins a block (ignored unless IDLE)
- bitwidth_d  in  5  bits per value; 0 or >16 treated as 16
- transmitted_values  in  CNT_W  number of values in the block
- rcv_valid  in  1  input value valid
- rcv_data  in  DATA_W  value in bits [b-1:0]; upper bits ignored (masked)
- rcv_ready  out  1  input accepted this cycle when rcv_valid && rcv_ready
- trm_valid  out  1  output word valid
- trm_data  out  DATA_W  packed word
- trm_last  out  1  marks final word of block
- trm_ready  in  1  downstream ready
- busy  out  1  high in any state but IDLE

Behaviour:
- Reset:
  - state=IDLE, acc=0, fill=0, remaining=0.
  - All outputs 0: rcv_ready, trm_valid, trm_data, trm_last, busy.
  - Reset asserted mid-block abandons the block immediately; no word is emitted after release until the next start.
- State registers: acc[31:0] holds pending bits, fill[5:0] holds the valid bit count (0..31), remaining[CNT_W-1:0] holds values still to accept.
- IDLE:
  - On start, latch b and mask=(1<<b)-1, then set remaining=transmitted_values.
  - Next state is PACK if the count is nonzero, else stay in IDLE (done pulse only with the optional feature).
- PACK:
  - trm_valid = (fill>=16).
  - trm_data = acc[15:0]. trm_data is registered, and is held stable while trm_valid && !trm_ready.
  - rcv_ready = (fill<16) || trm_ready. Combinational path trm_ready->rcv_ready is allowed. Gives full throughput at b=16.
  - Accept: acc |= (rcv_data & mask) << fill; fill += b; remaining -= 1.
  - Emit (trm_valid && trm_ready): acc >>= 16; fill -= 16.
  - Simultaneous accept and emit: acc = (acc>>16) | (data_m << (fill-16)); fill = fill - 16 + b. fill never exceeds 31.
  - When the accept that sets remaining to 0 occurs, go to FLUSH. rcv_ready is 0 from then on.
- FLUSH:
  - trm_valid = (fill>0).
  - trm_last = 1 on the word for which fill<=16, i.e. the word emptying the buffer.
  - Bits at and above fill in the last word are 0.
  - On the last handshake, go to IDLE with acc=0 and fill=0. If fill==0 on entry, go to IDLE directly with no word.
- Word count per block = ceil(N*b/16). trm_last appears exactly once per block.
- start while busy is ignored. bitwidth_d and transmitted_values changes after start have no effect.

Optional Feature:
- Macro PACKER_PERF_COUNTER_EN.
- Defined: adds outputs done (1-cycle pulse on the transition into IDLE from PACK/FLUSH, or on start with count 0), in_stall_cycles and out_stall_cycles (CNT_W each).
  - in_stall_cycles counts cycles with busy && rcv_valid && !rcv_ready.
  - out_stall_cycles counts cycles with trm_valid && !trm_ready.
  - Both counters clear on start and saturate at all-ones; reset value 0.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- b=4, N=8, values 1..8, trm_ready=1 -> words 0x4321 then 0x8765; trm_last only on 0x8765; IDLE after.
- b=5, N=4, values 0x1F,0,0x1F,0 -> 0x7C1F then 0x0000 with trm_last (4-bit partial, zero-padded).
- b=4, rcv_data=0xFFF3 x4 -> single word 0x3333 (upper input bits masked).
- b=16, N=3, rcv_valid and trm_ready always 1 -> one accept per cycle, 3 consecutive words, last on third.
- b=4, N=8, trm_ready low 4 cycles while the first word is valid -> trm_data holds 0x4321 stable, rcv_ready low once fill>=16, no data lost; with PACKER_PERF_COUNTER_EN, out_stall_cycles=4.
- Reset mid-PACK after 3 values, then start with N=0 -> no trm_valid in either block, busy=0; with PACKER_PERF_COUNTER_EN, done pulses once on the N=0 start.
